serial_magnitude_comparator: RTL and testbench

//  - Bit-serial magnitude comparator. Operands A and B arrive one bit pair per beat, MSB first, over a valid/ready stream.
//  - Delivers a one-hot A_greater/A_equal/A_less result over a second valid/ready handshake.
//  - Sits on the consumer end of serial operand links. Replaces parallel comparator_1bit trees where operands are only available serially.

---
 rtl/serial_magnitude_comparator_pkg.sv | 21 ++
 rtl/serial_magnitude_comparator_cmp_bit_cell.sv | 38 +++
 rtl/serial_magnitude_comparator.sv | 107 ++++++++++
 tb/tb_serial_magnitude_comparator.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/serial_magnitude_comparator_pkg.sv
// Shared definitions for the bit-serial magnitude comparator:
// FSM state codes, two-bit decision codes and the unsigned bit-pair decision.
// Optional feature macro: CMP_SIGNED_EN (two's complement operands).
package serial_magnitude_comparator_pkg;

    // FSM state encodings
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COLLECT = 2'd1;
    localparam logic [1:0] S_RESULT  = 2'd2;

    // Running comparison decision
    localparam logic [1:0] DEC_EQ = 2'b00;
    localparam logic [1:0] DEC_GT = 2'b01;
    localparam logic [1:0] DEC_LT = 2'b10;

    // Decision for a single differing bit pair when both are weighted positively
    function automatic logic [1:0] unsigned_dec(input logic a, input logic b);
        return a ? DEC_GT : DEC_LT;
    endfunction

endpackage

// File: rtl/serial_magnitude_comparator_cmp_bit_cell.sv
// cmp_bit_cell: combinational next-decision for one MSB-first bit pair.
// A decided (GT/LT) result is frozen; only an "equal so far" decision is updated.
// Optional feature macro: CMP_SIGNED_EN -- the first beat is a sign bit, so a
// differing first pair decides the opposite way from an ordinary bit.
module cmp_bit_cell
    import serial_magnitude_comparator_pkg::*;
(
    input  logic [1:0] prev_dec,
    input  logic       a,
    input  logic       b,
    input  logic       is_first,
    output logic [1:0] next_dec
);

`ifndef CMP_SIGNED_EN
    // The sign-bit position is irrelevant when every bit is unsigned.
    logic unused_first;
    assign unused_first = is_first;
`endif

    // Update the decision only while it is still undecided and the bits differ
    always_comb begin
        // NOTE: default assignment first so every path drives next_dec and no latch is inferred.
        next_dec = prev_dec;
        if (prev_dec == DEC_EQ && a != b) begin
`ifdef CMP_SIGNED_EN
            if (is_first) begin
                next_dec = a ? DEC_LT : DEC_GT;
            end else begin
                next_dec = unsigned_dec(a, b);
            end
`else
            next_dec = unsigned_dec(a, b);
`endif
        end
    end

endmodule

// File: rtl/serial_magnitude_comparator.sv
// serial_magnitude_comparator: bit-serial MSB-first compare of A and B over a
// valid/ready beat stream, with a one-hot GT/EQ/LT result on a second
// valid/ready handshake. Frames longer than WIDTH beats are force-closed and
// flagged with frame_err.
// Optional feature macro: CMP_SIGNED_EN (two's complement operands).
module serial_magnitude_comparator
    import serial_magnitude_comparator_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_a,
    input  logic             in_b,
    input  logic             in_last,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             A_greater,
    output logic             A_equal,
    output logic             A_less,
    output logic [CNT_W-1:0] res_bits,
    output logic             frame_err
);

    logic [1:0]       state;
    logic [1:0]       decision;
    logic [CNT_W-1:0] cnt;
    logic             err_q;

    logic             accept;
    logic             is_first;
    logic [1:0]       prev_dec;
    logic [1:0]       cell_dec;
    logic [CNT_W-1:0] beat_num;
    logic             at_limit;
    logic             close_frame;

    // Handshake and frame-position terms for the current beat
    assign in_ready    = (state != S_RESULT);
    assign res_valid   = (state == S_RESULT);
    assign accept      = in_valid & in_ready;
    assign is_first    = (state == S_IDLE);
    // The first beat starts from "equal" regardless of the stale register value.
    assign prev_dec    = is_first ? DEC_EQ : decision;
    assign beat_num    = is_first ? CNT_W'(1) : cnt + CNT_W'(1);
    assign at_limit    = (beat_num == CNT_W'(WIDTH));
    assign close_frame = in_last | at_limit;

    cmp_bit_cell u_cell (
        .prev_dec (prev_dec),
        .a        (in_a),
        .b        (in_b),
        .is_first (is_first),
        .next_dec (cell_dec)
    );

    // FSM, beat counter and decision/error registers
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so all updates see pre-edge values.
        if (rst) begin
            state    <= S_IDLE;
            decision <= DEC_EQ;
            cnt      <= '0;
            err_q    <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_COLLECT: begin
                    if (accept) begin
                        decision <= cell_dec;
                        cnt      <= beat_num;
                        if (close_frame) begin
                            state <= S_RESULT;
                            err_q <= ~in_last;
                        end else begin
                            state <= S_COLLECT;
                        end
                    end
                end
                S_RESULT: begin
                    if (res_ready) begin
                        state    <= S_IDLE;
                        decision <= DEC_EQ;
                        cnt      <= '0;
                        err_q    <= 1'b0;
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    decision <= DEC_EQ;
                    cnt      <= '0;
                    err_q    <= 1'b0;
                end
            endcase
        end
    end

    // Result outputs are gated by res_valid so they read 0 outside S_RESULT
    assign A_greater = res_valid & (decision == DEC_GT);
    assign A_equal   = res_valid & (decision == DEC_EQ);
    assign A_less    = res_valid & (decision == DEC_LT);
    assign res_bits  = res_valid ? cnt : '0;
    assign frame_err = res_valid & err_q;

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Scoreboard bench for serial_magnitude_comparator (WIDTH=8).
// Stimulus pushes hand-computed expectations; a negedge monitor pops and
// compares on every result handshake. Expectations track CMP_SIGNED_EN.
module tb_serial_magnitude_comparator;

    localparam int WIDTH = 8;
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic             in_a;
    logic             in_b;
    logic             in_last;
    logic             res_valid;
    logic             res_ready;
    logic             A_greater;
    logic             A_equal;
    logic             A_less;
    logic [CNT_W-1:0] res_bits;
    logic             frame_err;

    typedef struct {
        string      name;
        logic [7:0] a;
        logic [7:0] b;
        int         nbits;
        bit         last;
        logic [2:0] flags;   // {gt, eq, lt}
        logic       err;
    } vec_t;

    typedef struct {
        string            name;
        logic [2:0]       flags;
        logic [CNT_W-1:0] bits;
        logic             err;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    serial_magnitude_comparator #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_last   (in_last),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .A_greater (A_greater),
        .A_equal   (A_equal),
        .A_less    (A_less),
        .res_bits  (res_bits),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: compare every accepted result against the scoreboard head
    always @(negedge clk) begin
        if (!rst && res_valid && res_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_result", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({e.name, "_flags"}, {29'd0, A_greater, A_equal, A_less}, {29'd0, e.flags});
                check({e.name, "_bits"}, 32'(res_bits), 32'(e.bits));
                check({e.name, "_err"}, 32'(frame_err), 32'(e.err));
                check({e.name, "_onehot"}, 32'($onehot({A_greater, A_equal, A_less})), 32'd1);
            end
        end
    end

    task automatic idle_junk();
        in_valid = 1'b0;
        in_a     = 1'($urandom);
        in_b     = 1'($urandom);
        in_last  = 1'($urandom);
    endtask

    task automatic drive_beat(input logic a, input logic b, input logic last);
        int guard = 0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_last  = last;
        while (!in_ready && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!in_ready) check("in_ready_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        idle_junk();
    endtask

    task automatic send_frame(input vec_t v, input bit rnd);
        exp_t e;
        e.name  = v.name;
        e.flags = v.flags;
        e.bits  = CNT_W'(v.nbits);
        e.err   = v.err;
        sb.push_back(e);
        for (int i = v.nbits - 1; i >= 0; i--) begin
            if (rnd) begin
                repeat ($urandom_range(0, 2)) begin
                    idle_junk();
                    @(posedge clk); #1;
                end
            end
            drive_beat(v.a[i], v.b[i], v.last && (i == 0));
        end
    endtask

    task automatic drain();
        int guard = 0;
        while (sb.size() != 0 && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
    endtask

    task automatic check_idle(input string name);
        check({name, "_in_ready"}, 32'(in_ready), 32'd1);
        check({name, "_res_valid"}, 32'(res_valid), 32'd0);
        check({name, "_flags"}, {29'd0, A_greater, A_equal, A_less}, 32'd0);
        check({name, "_bits"}, 32'(res_bits), 32'd0);
        check({name, "_err"}, 32'(frame_err), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs.push_back('{"gt_a5_a3",   8'hA5, 8'hA3, 8, 1'b1, 3'b100, 1'b0});
        vecs.push_back('{"eq_3c_hold", 8'h3C, 8'h3C, 8, 1'b1, 3'b010, 1'b0});
`ifdef CMP_SIGNED_EN
        vecs.push_back('{"one_beat",   8'h00, 8'h01, 1, 1'b1, 3'b100, 1'b0});
`else
        vecs.push_back('{"one_beat",   8'h00, 8'h01, 1, 1'b1, 3'b001, 1'b0});
`endif
        vecs.push_back('{"nolast_eq",  8'h0F, 8'h0F, 8, 1'b0, 3'b010, 1'b1});
        vecs.push_back('{"lt_01_02",   8'h01, 8'h02, 8, 1'b1, 3'b001, 1'b0});
`ifdef CMP_SIGNED_EN
        vecs.push_back('{"s_80_01",    8'h80, 8'h01, 8, 1'b1, 3'b001, 1'b0});
        vecs.push_back('{"s_ff_00",    8'hFF, 8'h00, 8, 1'b1, 3'b001, 1'b0});
`else
        vecs.push_back('{"u_80_01",    8'h80, 8'h01, 8, 1'b1, 3'b100, 1'b0});
        vecs.push_back('{"u_ff_00",    8'hFF, 8'h00, 8, 1'b1, 3'b100, 1'b0});
`endif
        vecs.push_back('{"lt_4b_9_a",  8'h09, 8'h0A, 4, 1'b1, 3'b001, 1'b0});
        vecs.push_back('{"gt_3b_3_2",  8'h03, 8'h02, 3, 1'b1, 3'b100, 1'b0});
        vecs.push_back('{"nolast_lt",  8'h5A, 8'h5B, 8, 1'b0, 3'b001, 1'b1});

        rst       = 1'b1;
        res_ready = 1'b1;
        idle_junk();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_idle("reset");

        // First frame with in_valid held high: result the cycle after beat 8
        send_frame(vecs[0], 1'b0);
        check("latency_res_valid", 32'(res_valid), 32'd1);
        drain();

        // Equal frame held by backpressure for 5 cycles
        res_ready = 1'b0;
        send_frame(vecs[1], 1'b0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("hold_res_valid", 32'(res_valid), 32'd1);
            check("hold_A_equal", 32'(A_equal), 32'd1);
            check("hold_in_ready", 32'(in_ready), 32'd0);
            check("hold_bits", 32'(res_bits), 32'd8);
        end
        @(posedge clk); #1;
        res_ready = 1'b1;
        @(posedge clk); #1;
        check_idle("after_handshake");

        // Remaining directed frames back-to-back
        for (int i = 2; i < vecs.size(); i++) send_frame(vecs[i], 1'b0);
        drain();

        // Reset on beat 4 of a frame; nothing from it may appear
        for (int i = 7; i >= 5; i--) drive_beat(1'b1, 1'b0, 1'b0);
        in_valid = 1'b1;
        in_a     = 1'b1;
        in_b     = 1'b0;
        in_last  = 1'b0;
        rst      = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        idle_junk();
        check_idle("mid_frame_reset");
        send_frame(vecs[4], 1'b0);
        drain();

        // Same frames again with random in_valid gaps
        for (int i = 0; i < vecs.size(); i++) send_frame(vecs[i], 1'b1);
        drain();

        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
